// File: rtl/mem_dma_pkg.sv
// Shared types and helpers for the burst DMA command engine.
package mem_dma_pkg;

    localparam int DEF_BEAT_BYTES = 8;
    localparam int DEF_MEM_BYTES  = 1500;
    localparam int DEF_LEN_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_state_t;

    typedef struct packed {
        logic                     write;
        logic [31:0]              addr;
        logic [DEF_LEN_W-1:0]     len;
    } dma_cmd_t;

    function automatic logic [3:0] beat_len(input logic [31:0] rem,
                                            input logic [3:0]  bb);
        return (rem < 32'(bb)) ? rem[3:0] : bb;
    endfunction

endpackage

// File: rtl/mem_dma_rd_buf.sv
// One-entry valid/ready output register for read beats.
module mem_dma_rd_buf (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] in_data,
    input  logic [3:0]   in_bytes,
    input  logic         in_last,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [127:0] rd_data,
    output logic [3:0]   rd_bytes,
    output logic         rd_last
);

    logic         valid_q, valid_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   bytes_q, bytes_d;
    logic         last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bytes_d = bytes_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            bytes_d = in_bytes;
            last_d  = in_last;
        end else if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bytes_q <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            bytes_q <= bytes_d;
            last_q  <= last_d;
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign rd_bytes = bytes_q;
    assign rd_last  = last_q;

endmodule

// File: rtl/mem_burst_dma.sv
// Command engine: splits (addr, len, dir) into beats on the scratch memory port.
module mem_burst_dma
    import mem_dma_pkg::*;
#(
    parameter int BEAT_BYTES = DEF_BEAT_BYTES,
    parameter int MEM_BYTES  = DEF_MEM_BYTES,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [127:0]     wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [127:0]     rd_data,
    output logic [3:0]       rd_bytes,
    output logic             rd_last,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic             mem_rdwr,
    output logic             mem_en,
    output logic [31:0]      mem_addr,
    output logic [127:0]     mem_wr_data,
    output logic [3:0]       mem_ctrl,
    input  logic [127:0]     mem_rd_data
);

    dma_state_t       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic [3:0]       beat;
    logic             last;
    logic             range_bad;
    logic             wr_fire;
    logic             rd_load;
    logic             rd_end;
    logic [127:0]     rd_masked;

    assign beat = beat_len(32'(rem_q), 4'(BEAT_BYTES));
    assign last = (rem_q <= LEN_W'(BEAT_BYTES));
    assign range_bad = (cmd_len == '0) ||
        (({1'b0, cmd_addr} + 33'(cmd_len)) > 33'(MEM_BYTES));
    assign wr_fire = (state_q == WR) && wr_valid;
    assign rd_load = (state_q == RD) && (rem_q != '0) &&
        (!rd_valid || rd_ready);
    assign rd_end  = rd_valid && rd_ready && rd_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) state_d = range_bad ? DONE :
                                 (cmd_write ? WR : RD);
            RD:   if (rd_end) state_d = DONE;
            WR:   if (wr_fire && last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        err_d  = err_q;
        if (state_q == IDLE && cmd_valid) begin
            addr_d = cmd_addr;
            rem_d  = cmd_len;
            err_d  = range_bad;
        end else if (wr_fire || rd_load) begin
            addr_d = addr_q + 32'(beat);
            rem_d  = rem_q - LEN_W'(beat);
        end
    end

    always_comb begin
        cmd_ready   = (state_q == IDLE);
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        err         = (state_q == DONE) && err_q;
        wr_ready    = (state_q == WR);
        mem_en      = wr_fire || rd_load;
        mem_rdwr    = wr_fire;
        mem_addr    = mem_en ? addr_q : '0;
        mem_wr_data = wr_fire ? wr_data : '0;
        mem_ctrl    = mem_en ? beat : '0;
    end

    // Bytes beyond the beat are not part of the transfer; present them as zero.
    always_comb begin
        rd_masked = '0;
        for (int k = 0; k < 16; k++) begin
            if (k < int'(beat)) rd_masked[8*k +: 8] = mem_rd_data[8*k +: 8];
        end
    end

    mem_dma_rd_buf u_rd_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_load),
        .in_data  (rd_masked),
        .in_bytes (beat),
        .in_last  (last),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_bytes (rd_bytes),
        .rd_last  (rd_last)
    );

endmodule

// File: tb/tb_mem_burst_dma.sv
// Self-checking bench for mem_burst_dma with a byte memory model and scoreboards.
module tb_mem_burst_dma;

    localparam int MEMSZ = 1500;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_write = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [15:0]  cmd_len = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [127:0] wr_data = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [127:0] rd_data;
    logic [3:0]   rd_bytes;
    logic         rd_last;
    logic         done, err, busy;
    logic         mem_rdwr, mem_en;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wr_data;
    logic [3:0]   mem_ctrl;
    logic [127:0] mem_rd_data;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   b;
        logic         l;
    } rd_exp_t;

    typedef struct {
        logic [31:0]  a;
        logic [3:0]   c;
        logic [127:0] d;
    } wr_exp_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];

    logic [7:0] mem [0:MEMSZ-1];
    logic [7:0] ref_mem [0:MEMSZ-1];

    int n_chk = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    logic         prev_stall = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_bytes;
    logic         prev_last;

    always #5 clk = ~clk;

    mem_burst_dma dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_bytes    (rd_bytes),
        .rd_last     (rd_last),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .mem_rdwr    (mem_rdwr),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_ctrl    (mem_ctrl),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [7:0] pat(input int k);
        return 8'((k * 7 + 3) & 255);
    endfunction

    initial begin
        for (int k = 0; k < MEMSZ; k++) begin
            mem[k] = pat(k);
            ref_mem[k] = pat(k);
        end
    end

    always_comb begin
        mem_rd_data = '0;
        for (int k = 0; k < 16; k++) begin
            if (int'(mem_addr) + k < MEMSZ)
                mem_rd_data[8*k +: 8] = mem[int'(mem_addr) + k];
        end
    end

    always @(posedge clk) begin
        if (mem_en && mem_rdwr) begin
            for (int k = 0; k < int'(mem_ctrl); k++)
                mem[int'(mem_addr) + k] <= mem_wr_data[8*k +: 8];
        end
    end

    // Scoreboard pops and stall-stability checks
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (mem_en) en_cnt++;
            if (done) done_cnt++;
            if (mem_en && mem_rdwr) begin
                n_chk++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_beat unexpected addr=%0d ctrl=%0d",
                             mem_addr, mem_ctrl);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    if (mem_addr !== e.a || mem_ctrl !== e.c ||
                        mem_wr_data !== e.d) begin
                        n_fail++;
                        $display("FAIL wr_beat got a=%0d c=%0d d=%h want a=%0d c=%0d d=%h",
                                 mem_addr, mem_ctrl, mem_wr_data, e.a, e.c, e.d);
                    end
                end
            end
            if (prev_stall) begin
                n_chk++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data ||
                    rd_bytes !== prev_bytes || rd_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL rd_stall got v=%b d=%h want v=1 d=%h",
                             rd_valid, rd_data, prev_data);
                end
            end
            if (rd_valid && rd_ready) begin
                n_chk++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_beat unexpected d=%h", rd_data);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    if (rd_data !== e.d || rd_bytes !== e.b || rd_last !== e.l) begin
                        n_fail++;
                        $display("FAIL rd_beat got d=%h b=%0d l=%b want d=%h b=%0d l=%b",
                                 rd_data, rd_bytes, rd_last, e.d, e.b, e.l);
                    end
                end
            end
            prev_stall <= rd_valid && !rd_ready;
            prev_data  <= rd_data;
            prev_bytes <= rd_bytes;
            prev_last  <= rd_last;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int a, input int l);
        int rem;
        rem = l;
        while (rem > 0) begin
            rd_exp_t e;
            int b;
            b = (rem < 8) ? rem : 8;
            e.d = '0;
            for (int k = 0; k < b; k++) e.d[8*k +: 8] = ref_mem[a + k];
            e.b = 4'(b);
            e.l = (rem <= 8);
            rq.push_back(e);
            a += b;
            rem -= b;
        end
    endtask

    task automatic issue_cmd(input logic w, input int a, input int l);
        bit ok;
        ok = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = 32'(a);
        cmd_len   = 16'(l);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        step();
        cmd_valid = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cmd_accept got cmd_ready=0 want 1");
        end
    endtask

    task automatic drive_wr(input int a, input int c);
        wr_exp_t e;
        bit ok;
        ok = 0;
        e.a = 32'(a);
        e.c = 4'(c);
        e.d = {$urandom, $urandom, $urandom, $urandom};
        wr_valid = 1'b1;
        wr_data  = e.d;
        wq.push_back(e);
        for (int k = 0; k < c; k++) ref_mem[a + k] = e.d[8*k +: 8];
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (wr_ready) begin
                ok = 1;
                break;
            end
        end
        step();
        wr_valid = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wr_ready got 0 want 1");
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && busy; t++) step();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        n_chk++;
        if ({cmd_ready, busy, done, err, mem_en, rd_valid, wr_ready, mem_addr} !==
            {1'b1, 6'b0, 32'b0}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b busy=%b done=%b err=%b en=%b rv=%b wr=%b want 1 0 0 0 0 0 0",
                     cmd_ready, busy, done, err, mem_en, rd_valid, wr_ready);
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_write();
        issue_cmd(1'b1, 0, 20);
        drive_wr(0, 8);
        drive_wr(8, 8);
        drive_wr(16, 4);
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_done got done=%b err=%b want 1 0", done, err);
        end
        step();
        for (int k = 0; k < 24; k++) begin
            n_chk++;
            if (mem[k] !== ref_mem[k]) begin
                n_fail++;
                $display("FAIL write_mem[%0d] got %h want %h", k, mem[k], ref_mem[k]);
            end
        end
        n_chk++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL write_beats got %0d pending want 0", wq.size());
        end
        wait_idle();
    endtask

    task automatic run_read(input int a, input int l,
                            input logic [3:0] rdy_pat, input string nm);
        bit seen;
        int en0;
        seen = 0;
        en0 = en_cnt;
        push_rd(a, l);
        rd_ready = rdy_pat[0];
        issue_cmd(1'b0, a, l);
        for (int t = 0; t < 60; t++) begin
            rd_ready = rdy_pat[(t + 1) % 4];
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            step();
        end
        n_chk++;
        if (!seen || err !== 1'b0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_done got seen=%0d err=%b left=%0d want 1 0 0",
                     nm, seen, err, rq.size());
        end
        n_chk++;
        if (en_cnt - en0 != (l + 7) / 8) begin
            n_fail++;
            $display("FAIL %s_loads got %0d want %0d", nm, en_cnt - en0, (l + 7) / 8);
        end
        step();
        rd_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_read();
        run_read(0, 20, 4'b1111, "read");
    endtask

    task automatic test_backpressure();
        run_read(40, 24, 4'b1001, "stall");
    endtask

    task automatic test_err(input int a, input int l, input string nm);
        int en0;
        en0 = en_cnt;
        issue_cmd(1'b1, a, l);
        @(negedge clk);
        n_chk++;
        if (done !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL %s got done=%b err=%b want 1 1", nm, done, err);
        end
        step();
        step();
        n_chk++;
        if (en_cnt != en0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_noaccess got en=%0d busy=%b want 0 0",
                     nm, en_cnt - en0, busy);
        end
    endtask

    task automatic test_range();
        test_err(1496, 8, "err_range");
        test_err(0, 0, "err_len0");
        run_read(1492, 8, 4'b1111, "edge_read");
    endtask

    task automatic test_mid_reset();
        int en0, d0;
        issue_cmd(1'b1, 200, 40);
        drive_wr(200, 8);
        drive_wr(208, 8);
        rst = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got busy=%b rdy=%b want 0 1", busy, cmd_ready);
        end
        en0 = en_cnt;
        d0 = done_cnt;
        wr_valid = 1'b1;
        for (int t = 0; t < 4; t++) step();
        wr_valid = 1'b0;
        n_chk++;
        if (en_cnt != en0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet got en=%0d done=%0d want 0 0",
                     en_cnt - en0, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        int acc, dn;
        acc = 0;
        dn = 0;
        push_rd(300, 16);
        push_rd(300, 16);
        rd_ready  = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'd300;
        cmd_len   = 16'd16;
        cmd_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc++;
            if (done) begin
                dn++;
                n_chk++;
                if (cmd_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_done_ready got %b want 0", cmd_ready);
                end
                if (dn == 2) break;
            end
            step();
            if (acc == 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        n_chk++;
        if (acc != 2 || dn != 2 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b got acc=%0d done=%0d left=%0d want 2 2 0",
                     acc, dn, rq.size());
        end
        step();
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_range();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
